// File: rtl/riscv_i32_debug_fetch_sequencer.sv
// Debug fetch sequencer: sits between the pipeline fetch port and instruction memory,
// handling halt drain, debug instruction injection, retirement acks and dret restart.
module riscv_i32_debug_fetch_sequencer #(
  parameter logic [2:0] DEBUG_MODE = 3'b100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pipeline_ifetch_req__valid,
  input  logic [31:0] pipeline_ifetch_req__address,
  input  logic        pipeline_ifetch_req__sequential,
  input  logic [2:0]  pipeline_ifetch_req__mode,
  input  logic        pipeline_ifetch_req__flush,
  output logic        ifetch_req__valid,
  output logic [31:0] ifetch_req__address,
  output logic        ifetch_req__sequential,
  output logic [2:0]  ifetch_req__mode,
  output logic        ifetch_req__flush,
  input  logic        ifetch_resp__valid,
  input  logic        ifetch_resp__debug,
  input  logic [31:0] ifetch_resp__data,
  input  logic [2:0]  ifetch_resp__mode,
  input  logic        ifetch_resp__error,
  input  logic [1:0]  ifetch_resp__tag,
  output logic        pipeline_ifetch_resp__valid,
  output logic        pipeline_ifetch_resp__debug,
  output logic [31:0] pipeline_ifetch_resp__data,
  output logic [2:0]  pipeline_ifetch_resp__mode,
  output logic        pipeline_ifetch_resp__error,
  output logic [1:0]  pipeline_ifetch_resp__tag,
  input  logic        debug_control__valid,
  input  logic        debug_control__kill_fetch,
  input  logic        debug_control__halt_request,
  input  logic        debug_control__fetch_dret,
  input  logic [31:0] debug_control__data,
  output logic        debug_response__valid,
  output logic        debug_response__kill_fetch,
  output logic        debug_response__halt_request,
  output logic        debug_response__fetch_dret,
  output logic [31:0] debug_response__data,
  input  logic        pipeline_trace__instr_valid,
  input  logic        pipeline_trace__rfw_data_valid,
  input  logic [31:0] pipeline_trace__rfw_data,
  input  logic        pipeline_trace__trap
);

  typedef enum logic [2:0] {
    ST_RUNNING      = 3'd0,
    ST_HALT_PENDING = 3'd1,
    ST_HALTED       = 3'd2,
    ST_ISSUE_WAIT   = 3'd3,
    ST_EXECUTE      = 3'd4,
    ST_RESUME       = 3'd5
  } state_t;

  state_t      state_r, state_s;
  logic        outstanding_r, outstanding_s;
  logic [31:0] instr_r, instr_s;
  logic        kill_supp_r, kill_supp_s;
  logic        inject_r, inject_s;
  logic        cmd_kill_s, cmd_halt_s, supp_active_s, drained_s;
  logic        rsp_valid_s, rsp_kill_s, rsp_halt_s, rsp_dret_s, rsp_exec_s;
  logic [31:0] rsp_data_s;

  assign cmd_kill_s = debug_control__valid & debug_control__kill_fetch &
                      ((state_r == ST_RUNNING) | (state_r == ST_HALT_PENDING));
  assign cmd_halt_s = debug_control__valid & debug_control__halt_request &
                      (state_r == ST_RUNNING);
  assign supp_active_s = kill_supp_r | cmd_kill_s;
  // Valid only on paths where no new memory request is issued this cycle.
  assign drained_s = ~outstanding_r | ifetch_resp__valid | cmd_kill_s;

  // Next-state, fetch-path muxing and debug acknowledge generation.
  always_comb begin
    state_s                     = state_r;
    instr_s                     = instr_r;
    inject_s                    = inject_r;
    kill_supp_s                 = kill_supp_r;
    outstanding_s               = outstanding_r;
    ifetch_req__valid           = 1'b0;
    ifetch_req__address         = pipeline_ifetch_req__address;
    ifetch_req__sequential      = pipeline_ifetch_req__sequential;
    ifetch_req__mode            = pipeline_ifetch_req__mode;
    ifetch_req__flush           = pipeline_ifetch_req__flush;
    pipeline_ifetch_resp__valid = 1'b0;
    pipeline_ifetch_resp__debug = ifetch_resp__debug;
    pipeline_ifetch_resp__data  = ifetch_resp__data;
    pipeline_ifetch_resp__mode  = ifetch_resp__mode;
    pipeline_ifetch_resp__error = ifetch_resp__error;
    pipeline_ifetch_resp__tag   = ifetch_resp__tag;
    rsp_kill_s                  = 1'b0;
    rsp_halt_s                  = 1'b0;
    rsp_dret_s                  = 1'b0;
    rsp_exec_s                  = 1'b0;
    rsp_data_s                  = 32'd0;

    case (state_r)
      ST_RUNNING: begin
        ifetch_req__valid = pipeline_ifetch_req__valid & ~cmd_kill_s & ~cmd_halt_s;
        pipeline_ifetch_resp__valid = ifetch_resp__valid & ~supp_active_s;
        if (cmd_halt_s) begin
          state_s    = drained_s ? ST_HALTED : ST_HALT_PENDING;
          rsp_halt_s = drained_s;
        end else begin
          state_s = state_r;
        end
      end
      ST_HALT_PENDING: begin
        pipeline_ifetch_resp__valid = ifetch_resp__valid & ~supp_active_s;
        if (drained_s) begin
          state_s    = ST_HALTED;
          rsp_halt_s = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      ST_HALTED: begin
        // halt_request outranks dret; any flag set means the word is not an instruction.
        if (debug_control__valid & ~debug_control__halt_request & debug_control__fetch_dret) begin
          state_s = ST_RESUME;
        end else if (debug_control__valid & ~debug_control__halt_request &
                     ~debug_control__fetch_dret & ~debug_control__kill_fetch) begin
          instr_s = debug_control__data;
          state_s = ST_ISSUE_WAIT;
        end else begin
          state_s = state_r;
        end
      end
      ST_ISSUE_WAIT: begin
        if (inject_r) begin
          pipeline_ifetch_resp__valid = 1'b1;
          pipeline_ifetch_resp__debug = 1'b1;
          pipeline_ifetch_resp__data  = instr_r;
          pipeline_ifetch_resp__mode  = DEBUG_MODE;
          pipeline_ifetch_resp__error = 1'b0;
          pipeline_ifetch_resp__tag   = 2'd0;
          inject_s = 1'b0;
          state_s  = ST_EXECUTE;
        end else if (pipeline_ifetch_req__valid) begin
          inject_s = 1'b1;
        end else begin
          inject_s = 1'b0;
        end
      end
      ST_EXECUTE: begin
        if (pipeline_trace__instr_valid | pipeline_trace__trap) begin
          state_s    = ST_HALTED;
          rsp_exec_s = 1'b1;
          rsp_kill_s = pipeline_trace__trap;
          rsp_data_s = pipeline_trace__rfw_data_valid ? pipeline_trace__rfw_data : 32'd0;
        end else begin
          state_s = state_r;
        end
      end
      ST_RESUME: begin
        ifetch_req__valid = pipeline_ifetch_req__valid;
        ifetch_req__flush = 1'b1;
        if (pipeline_ifetch_req__valid) begin
          state_s    = ST_RUNNING;
          rsp_dret_s = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = ST_RUNNING;
      end
    endcase

    // A response arriving with the kill is itself the suppressed one.
    if (cmd_kill_s) begin
      rsp_kill_s  = 1'b1;
      kill_supp_s = ~ifetch_resp__valid;
    end else if (ifetch_resp__valid) begin
      kill_supp_s = 1'b0;
    end else begin
      kill_supp_s = kill_supp_r;
    end

    if (cmd_kill_s) begin
      outstanding_s = 1'b0;
    end else if (ifetch_req__valid) begin
      outstanding_s = 1'b1;
    end else if (ifetch_resp__valid) begin
      outstanding_s = 1'b0;
    end else begin
      outstanding_s = outstanding_r;
    end

    rsp_valid_s = rsp_exec_s | rsp_kill_s | rsp_halt_s | rsp_dret_s;
  end

  // State, tracking flags and registered debug acknowledge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r                      <= ST_RUNNING;
      outstanding_r                <= 1'b0;
      instr_r                      <= 32'd0;
      kill_supp_r                  <= 1'b0;
      inject_r                     <= 1'b0;
      debug_response__valid        <= 1'b0;
      debug_response__kill_fetch   <= 1'b0;
      debug_response__halt_request <= 1'b0;
      debug_response__fetch_dret   <= 1'b0;
      debug_response__data         <= 32'd0;
    end else begin
      state_r                      <= state_s;
      outstanding_r                <= outstanding_s;
      instr_r                      <= instr_s;
      kill_supp_r                  <= kill_supp_s;
      inject_r                     <= inject_s;
      debug_response__valid        <= rsp_valid_s;
      debug_response__kill_fetch   <= rsp_kill_s;
      debug_response__halt_request <= rsp_halt_s;
      debug_response__fetch_dret   <= rsp_dret_s;
      debug_response__data         <= rsp_data_s;
    end
  end

endmodule

// File: tb/tb_riscv_i32_debug_fetch_sequencer.sv
// Bench for riscv_i32_debug_fetch_sequencer: table-driven pass-through vectors, hand-written
// debug sequences, and an ack scoreboard checked whenever debug_response__valid rises.
module tb_riscv_i32_debug_fetch_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        p_req_valid, p_req_seq, p_req_flush;
  logic [31:0] p_req_addr;
  logic [2:0]  p_req_mode;
  logic        m_req_valid, m_req_seq, m_req_flush;
  logic [31:0] m_req_addr;
  logic [2:0]  m_req_mode;
  logic        m_rsp_valid, m_rsp_debug, m_rsp_error;
  logic [31:0] m_rsp_data;
  logic [2:0]  m_rsp_mode;
  logic [1:0]  m_rsp_tag;
  logic        p_rsp_valid, p_rsp_debug, p_rsp_error;
  logic [31:0] p_rsp_data;
  logic [2:0]  p_rsp_mode;
  logic [1:0]  p_rsp_tag;
  logic        dc_valid, dc_kill, dc_halt, dc_dret;
  logic [31:0] dc_data;
  logic        dr_valid, dr_kill, dr_halt, dr_dret;
  logic [31:0] dr_data;
  logic        tr_valid, tr_rfw_valid, tr_trap;
  logic [31:0] tr_rfw_data;

  riscv_i32_debug_fetch_sequencer #(.DEBUG_MODE(3'b100)) dut (
    .clk(clk), .reset(reset),
    .pipeline_ifetch_req__valid(p_req_valid), .pipeline_ifetch_req__address(p_req_addr),
    .pipeline_ifetch_req__sequential(p_req_seq), .pipeline_ifetch_req__mode(p_req_mode),
    .pipeline_ifetch_req__flush(p_req_flush),
    .ifetch_req__valid(m_req_valid), .ifetch_req__address(m_req_addr),
    .ifetch_req__sequential(m_req_seq), .ifetch_req__mode(m_req_mode),
    .ifetch_req__flush(m_req_flush),
    .ifetch_resp__valid(m_rsp_valid), .ifetch_resp__debug(m_rsp_debug),
    .ifetch_resp__data(m_rsp_data), .ifetch_resp__mode(m_rsp_mode),
    .ifetch_resp__error(m_rsp_error), .ifetch_resp__tag(m_rsp_tag),
    .pipeline_ifetch_resp__valid(p_rsp_valid), .pipeline_ifetch_resp__debug(p_rsp_debug),
    .pipeline_ifetch_resp__data(p_rsp_data), .pipeline_ifetch_resp__mode(p_rsp_mode),
    .pipeline_ifetch_resp__error(p_rsp_error), .pipeline_ifetch_resp__tag(p_rsp_tag),
    .debug_control__valid(dc_valid), .debug_control__kill_fetch(dc_kill),
    .debug_control__halt_request(dc_halt), .debug_control__fetch_dret(dc_dret),
    .debug_control__data(dc_data),
    .debug_response__valid(dr_valid), .debug_response__kill_fetch(dr_kill),
    .debug_response__halt_request(dr_halt), .debug_response__fetch_dret(dr_dret),
    .debug_response__data(dr_data),
    .pipeline_trace__instr_valid(tr_valid), .pipeline_trace__rfw_data_valid(tr_rfw_valid),
    .pipeline_trace__rfw_data(tr_rfw_data), .pipeline_trace__trap(tr_trap)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic kill;
    logic halt;
    logic dret;
    logic [31:0] data;
  } ack_t;
  ack_t exp_q[$];

  typedef struct {
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_seq;
    logic [2:0]  req_mode;
    logic        rsp_valid;
    logic        rsp_debug;
    logic [31:0] rsp_data;
    logic        rsp_error;
    logic [1:0]  rsp_tag;
    logic        exp_req_valid;
    logic [31:0] exp_req_addr;
    logic        exp_rsp_valid;
    logic [31:0] exp_rsp_data;
    logic        exp_rsp_debug;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle();
    p_req_valid = 1'b0; p_req_addr = 32'd0; p_req_seq = 1'b0; p_req_mode = 3'd0; p_req_flush = 1'b0;
    m_rsp_valid = 1'b0; m_rsp_debug = 1'b0; m_rsp_data = 32'd0; m_rsp_mode = 3'd0;
    m_rsp_error = 1'b0; m_rsp_tag = 2'd0;
    dc_valid = 1'b0; dc_kill = 1'b0; dc_halt = 1'b0; dc_dret = 1'b0; dc_data = 32'd0;
    tr_valid = 1'b0; tr_rfw_valid = 1'b0; tr_rfw_data = 32'd0; tr_trap = 1'b0;
  endtask

  task automatic cmd(input logic kill, input logic halt, input logic dret, input logic [31:0] data);
    dc_valid = 1'b1; dc_kill = kill; dc_halt = halt; dc_dret = dret; dc_data = data;
  endtask

  // Scoreboard: every ack the DUT raises must match the oldest expected ack.
  always @(negedge clk) begin
    if (dr_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: kill=%0b halt=%0b dret=%0b data=0x%08h expected no ack",
                 dr_kill, dr_halt, dr_dret, dr_data);
      end else begin
        ack_t e;
        e = exp_q.pop_front();
        chk("sb_ack_kill", 32'(dr_kill), 32'(e.kill));
        chk("sb_ack_halt", 32'(dr_halt), 32'(e.halt));
        chk("sb_ack_dret", 32'(dr_dret), 32'(e.dret));
        chk("sb_ack_data", dr_data, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 32'h0000_0100, 1'b0, 3'd3, 1'b1, 1'b0, 32'h0000_0013, 1'b0, 2'd0,
                1'b1, 32'h0000_0100, 1'b1, 32'h0000_0013, 1'b0};
    vecs[1] = '{1'b1, 32'h0000_0104, 1'b1, 3'd3, 1'b1, 1'b0, 32'hdead_beef, 1'b1, 2'd2,
                1'b1, 32'h0000_0104, 1'b1, 32'hdead_beef, 1'b0};
    vecs[2] = '{1'b0, 32'h0000_0200, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0000_0055, 1'b0, 2'd1,
                1'b0, 32'h0000_0200, 1'b0, 32'h0000_0055, 1'b0};
    vecs[3] = '{1'b0, 32'h0000_0000, 1'b0, 3'd0, 1'b1, 1'b1, 32'hffff_ffff, 1'b0, 2'd3,
                1'b0, 32'h0000_0000, 1'b1, 32'hffff_ffff, 1'b1};

    reset = 1'b1;
    idle();
    tick();
    tick();
    sample();
    chk("reset_dr_valid", 32'(dr_valid), 32'd0);
    chk("reset_dr_flags", {29'd0, dr_kill, dr_halt, dr_dret}, 32'd0);
    chk("reset_dr_data", dr_data, 32'd0);
    reset = 1'b0;
    tick();

    // Pass-through vectors in RUNNING.
    for (int i = 0; i < 4; i++) begin
      idle();
      p_req_valid = vecs[i].req_valid; p_req_addr = vecs[i].req_addr;
      p_req_seq = vecs[i].req_seq; p_req_mode = vecs[i].req_mode;
      m_rsp_valid = vecs[i].rsp_valid; m_rsp_debug = vecs[i].rsp_debug;
      m_rsp_data = vecs[i].rsp_data; m_rsp_error = vecs[i].rsp_error;
      m_rsp_tag = vecs[i].rsp_tag; m_rsp_mode = vecs[i].req_mode;
      sample();
      chk("pt_req_valid", 32'(m_req_valid), 32'(vecs[i].exp_req_valid));
      chk("pt_req_addr", m_req_addr, vecs[i].exp_req_addr);
      chk("pt_req_seq", 32'(m_req_seq), 32'(vecs[i].req_seq));
      chk("pt_req_mode", 32'(m_req_mode), 32'(vecs[i].req_mode));
      chk("pt_rsp_valid", 32'(p_rsp_valid), 32'(vecs[i].exp_rsp_valid));
      chk("pt_rsp_data", p_rsp_data, vecs[i].exp_rsp_data);
      chk("pt_rsp_debug", 32'(p_rsp_debug), 32'(vecs[i].exp_rsp_debug));
      chk("pt_rsp_error", 32'(p_rsp_error), 32'(vecs[i].rsp_error));
      chk("pt_rsp_tag", 32'(p_rsp_tag), 32'(vecs[i].rsp_tag));
      chk("pt_no_ack", 32'(dr_valid), 32'd0);
      tick();
    end

    // Halt with a fetch outstanding: halt at N, response at N+2, ack at N+3.
    idle(); p_req_valid = 1'b1; p_req_addr = 32'h300;
    sample(); chk("halt_pre_req", 32'(m_req_valid), 32'd1); tick();
    p_req_addr = 32'h304; cmd(1'b0, 1'b1, 1'b0, 32'd0);
    exp_q.push_back('{1'b0, 1'b1, 1'b0, 32'd0});
    sample(); chk("halt_blocks_n", 32'(m_req_valid), 32'd0); tick();
    dc_valid = 1'b0; dc_halt = 1'b0;
    sample(); chk("halt_blocks_n1", 32'(m_req_valid), 32'd0); chk("halt_no_ack_n1", 32'(dr_valid), 32'd0); tick();
    m_rsp_valid = 1'b1; m_rsp_data = 32'h0000_0abc;
    sample(); chk("halt_resp_fwd", 32'(p_rsp_valid), 32'd1); chk("halt_resp_data", p_rsp_data, 32'h0000_0abc);
    chk("halt_no_ack_n2", 32'(dr_valid), 32'd0); tick();
    m_rsp_valid = 1'b0;
    sample(); chk("halt_ack_n3", 32'(dr_valid), 32'd1); chk("halt_ack_flag", 32'(dr_halt), 32'd1);
    chk("halted_blocks_req", 32'(m_req_valid), 32'd0); tick();
    sample(); chk("halt_ack_one_cycle", 32'(dr_valid), 32'd0); tick();

    // Injection of addi x1,x0,1 and its retirement ack.
    idle(); m_rsp_valid = 1'b1; m_rsp_data = 32'h777; cmd(1'b0, 1'b0, 1'b0, 32'h0010_0093);
    sample(); chk("halted_resp_block", 32'(p_rsp_valid), 32'd0); tick();
    idle();
    sample(); chk("issue_wait_idle", 32'(p_rsp_valid), 32'd0); tick();
    p_req_valid = 1'b1; p_req_addr = 32'h800;
    sample(); chk("inj_req_not_fwd", 32'(m_req_valid), 32'd0); chk("inj_not_yet", 32'(p_rsp_valid), 32'd0); tick();
    p_req_valid = 1'b0;
    sample();
    chk("inj_valid", 32'(p_rsp_valid), 32'd1); chk("inj_debug", 32'(p_rsp_debug), 32'd1);
    chk("inj_mode", 32'(p_rsp_mode), 32'd4); chk("inj_data", p_rsp_data, 32'h0010_0093);
    chk("inj_error", 32'(p_rsp_error), 32'd0); chk("inj_tag", 32'(p_rsp_tag), 32'd0);
    tick();
    p_req_valid = 1'b1; tr_valid = 1'b1; tr_rfw_valid = 1'b1; tr_rfw_data = 32'd1;
    exp_q.push_back('{1'b0, 1'b0, 1'b0, 32'd1});
    sample(); chk("exec_hold_resp", 32'(p_rsp_valid), 32'd0); chk("exec_hold_req", 32'(m_req_valid), 32'd0); tick();
    idle();
    sample(); chk("retire_ack", 32'(dr_valid), 32'd1); chk("retire_data", dr_data, 32'd1); tick();

    // Trap during EXECUTE, then dret with forced flush.
    cmd(1'b0, 1'b0, 1'b0, 32'h0000_0073); sample(); tick();
    idle(); p_req_valid = 1'b1; sample(); tick();
    idle(); sample(); chk("inj2_data", p_rsp_data, 32'h0000_0073); chk("inj2_valid", 32'(p_rsp_valid), 32'd1); tick();
    tr_trap = 1'b1; tr_rfw_data = 32'h1234;
    exp_q.push_back('{1'b1, 1'b0, 1'b0, 32'd0});
    sample(); tick();
    idle(); p_req_valid = 1'b1; m_rsp_valid = 1'b1;
    sample(); chk("trap_ack_kill", 32'(dr_kill), 32'd1); chk("trap_halted_req", 32'(m_req_valid), 32'd0);
    chk("trap_halted_resp", 32'(p_rsp_valid), 32'd0); tick();
    idle(); cmd(1'b0, 1'b0, 1'b1, 32'd0); sample(); tick();
    idle(); p_req_valid = 1'b1; p_req_addr = 32'h400;
    exp_q.push_back('{1'b0, 1'b0, 1'b1, 32'd0});
    sample(); chk("resume_req_valid", 32'(m_req_valid), 32'd1); chk("resume_flush", 32'(m_req_flush), 32'd1);
    chk("resume_addr", m_req_addr, 32'h400); tick();
    p_req_addr = 32'h404;
    sample(); chk("dret_ack", 32'(dr_dret), 32'd1); chk("running_req", 32'(m_req_valid), 32'd1);
    chk("running_no_flush", 32'(m_req_flush), 32'd0); tick();
    idle(); m_rsp_valid = 1'b1; m_rsp_data = 32'h99;
    sample(); chk("running_resp", 32'(p_rsp_valid), 32'd1); tick();

    // Kill fetch: request blocked, next response suppressed, later one forwarded.
    idle(); p_req_valid = 1'b1; p_req_addr = 32'h600; sample(); tick();
    cmd(1'b1, 1'b0, 1'b0, 32'd0); exp_q.push_back('{1'b1, 1'b0, 1'b0, 32'd0});
    sample(); chk("kill_blocks_req", 32'(m_req_valid), 32'd0); tick();
    idle(); m_rsp_valid = 1'b1; m_rsp_data = 32'h11;
    sample(); chk("kill_suppress", 32'(p_rsp_valid), 32'd0); chk("kill_ack", 32'(dr_kill), 32'd1); tick();
    m_rsp_data = 32'h22;
    sample(); chk("kill_next_fwd", 32'(p_rsp_valid), 32'd1); chk("kill_next_data", p_rsp_data, 32'h22); tick();

    // Ignored dret while RUNNING; halt+dret together halts.
    idle(); cmd(1'b0, 1'b0, 1'b1, 32'd0); sample(); tick();
    idle(); m_rsp_valid = 1'b1; m_rsp_data = 32'h33;
    sample(); chk("dret_running_noack", 32'(dr_valid), 32'd0); chk("still_running", 32'(p_rsp_valid), 32'd1); tick();
    idle(); cmd(1'b0, 1'b1, 1'b1, 32'd0); exp_q.push_back('{1'b0, 1'b1, 1'b0, 32'd0});
    sample(); tick();
    idle(); p_req_valid = 1'b1;
    sample(); chk("halt_dret_halt", 32'(dr_halt), 32'd1); chk("halt_dret_nodret", 32'(dr_dret), 32'd0);
    chk("halt_dret_blocks", 32'(m_req_valid), 32'd0); tick();

    // Reset while in EXECUTE drops the retirement ack and restores pass-through.
    idle(); cmd(1'b0, 1'b0, 1'b0, 32'h1); sample(); tick();
    idle(); p_req_valid = 1'b1; sample(); tick();
    idle(); sample(); chk("inj3_valid", 32'(p_rsp_valid), 32'd1); tick();
    reset = 1'b1; tr_valid = 1'b1; tr_rfw_valid = 1'b1; tr_rfw_data = 32'h5;
    sample(); tick();
    reset = 1'b0; idle(); p_req_valid = 1'b1; p_req_addr = 32'h500; m_rsp_valid = 1'b1; m_rsp_data = 32'h44;
    sample(); chk("post_reset_noack", 32'(dr_valid), 32'd0); chk("post_reset_req", 32'(m_req_valid), 32'd1);
    chk("post_reset_addr", m_req_addr, 32'h500); chk("post_reset_resp", p_rsp_data, 32'h44);
    chk("post_reset_resp_valid", 32'(p_rsp_valid), 32'd1); tick();

    idle(); tick(); tick();
    chk("ack_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_i32_debug_fetch_sequencer.md
# riscv_i32_debug_fetch_sequencer

Controller between the RISC-V i32 pipeline's instruction-fetch port and the instruction memory. It sequences debug entry and exit. It passes fetches through in normal running. On a halt request it drains the outstanding fetch and blocks memory fetch. In the halted state it injects debugger-supplied instruction words into the pipeline as debug fetch responses, one at a time, and reports each one's retirement. On dret it restarts fetch with a forced flush.

## Interface
Parameters:
- DEBUG_MODE, 3'b100: value driven on pipeline_ifetch_resp__mode for injected instructions.

Ports. Clocking: one clock; reset is synchronous and active-high.
- clk  input  1  clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- pipeline_ifetch_req__{valid,address,sequential,mode,flush}  input  1/32/1/3/1  fetch request from the pipeline.
- ifetch_req__{valid,address,sequential,mode,flush}  output  1/32/1/3/1  fetch request to memory.
- ifetch_resp__{valid,debug,data,mode,error,tag}  input  1/1/32/3/1/2  memory fetch response.
- pipeline_ifetch_resp__{valid,debug,data,mode,error,tag}  output  1/1/32/3/1/2  fetch response to the pipeline.
- debug_control__{valid,kill_fetch,halt_request,fetch_dret,data}  input  1/1/1/1/32  debugger command; a one-cycle pulse when valid=1.
- debug_response__{valid,kill_fetch,halt_request,fetch_dret,data}  output  1/1/1/1/32  debugger acknowledge, registered.
- pipeline_trace__{instr_valid,rfw_data_valid,rfw_data,trap}  input  1/1/32/1  retirement trace from the pipeline.

## Operation
- The state register takes one of six values: RUNNING, HALT_PENDING, HALTED, ISSUE_WAIT, EXECUTE, RESUME.
- The `outstanding` flag tracks one in-flight fetch.
  - Set when ifetch_req__valid=1 in a cycle.
  - Cleared when ifetch_resp__valid=1.
  - If both occur in the same cycle, the flag stays set.
- RUNNING:
  - ifetch_req mirrors pipeline_ifetch_req.
  - pipeline_ifetch_resp mirrors ifetch_resp.
  - debug_control valid with halt_request goes to HALT_PENDING.
- kill_fetch with valid, in RUNNING or HALT_PENDING:
  - Forces ifetch_req__valid=0 that cycle.
  - Clears `outstanding`.
  - Suppresses pipeline_ifetch_resp__valid for the next response.
  - Acks with debug_response kill_fetch=1.
- HALT_PENDING:
  - ifetch_req__valid is forced 0.
  - Responses are still forwarded.
  - When `outstanding`=0, go to HALTED and pulse debug_response with halt_request=1.
- HALTED:
  - ifetch_req__valid=0 and pipeline_ifetch_resp__valid=0.
  - valid with fetch_dret goes to RESUME.
  - valid with no flag set captures data into `instr` and goes to ISSUE_WAIT.
- ISSUE_WAIT:
  - Waits for pipeline_ifetch_req__valid; the request is not forwarded to memory.
  - In the cycle after that request, drives pipeline_ifetch_resp with valid=1, debug=1, data=`instr`, mode=DEBUG_MODE, error=0, tag=0, for exactly one cycle.
  - Then goes to EXECUTE.
- EXECUTE:
  - Further pipeline requests are held (not forwarded, no response).
  - On pipeline_trace__instr_valid or trap, go to HALTED.
  - Pulse debug_response with valid=1 and data=rfw_data if rfw_data_valid, else 0. On a trap, also set kill_fetch=1 as the exception indicator.
- RESUME:
  - The first pipeline_ifetch_req__valid is forwarded with flush forced to 1.
  - Pulse debug_response with fetch_dret=1, then go to RUNNING.
- Priorities and ignored commands:
  - halt_request has priority over fetch_dret in the same command.
  - Commands outside the states listed above are ignored and get no response: halt outside RUNNING, dret outside HALTED, data outside HALTED.
- Reset values:
  - state=RUNNING, outstanding=0, instr=0, kill suppression cleared.
  - All debug_response fields 0.

## Timing
- The ifetch_req and pipeline_ifetch_resp paths are combinational from inputs and state; zero added latency while RUNNING.
- debug_response is registered and valid for exactly one cycle. It is asserted in the cycle after the triggering event:
  - halt acknowledge follows the cycle `outstanding` reaches 0;
  - the kill acknowledge follows the command cycle.
- Halt latency with nothing outstanding: the command in cycle N gives HALTED and the ack in cycle N+1.
- Injected response: request in cycle M gives the response in M+1.
- Reset asserted mid-operation:
  - Takes effect on the next edge; any state returns to RUNNING.
  - Any pending injected response or ack is dropped.

## Test plan
- Pass-through: pipeline requests address 0x100 and memory returns data 0x00000013. Required: ifetch_req is identical in the same cycle, pipeline_ifetch_resp data is 0x13 with debug=0, and debug_response__valid stays 0.
- Halt with a fetch outstanding: halt in cycle N and response in N+2. Required: ifetch_req__valid=0 from cycle N, the response is forwarded, and halt ack arrives in N+3.
- Injection: HALTED, data=0x00100093 (addi x1,x0,1), then a pipeline request. Required: the next cycle has resp debug=1, mode=3'b100, data 0x00100093. After trace retire with rfw_data=1, ack valid with data=1.
- Trap during EXECUTE: required ack with kill_fetch=1 and state HALTED. A following dret gives a flush=1 forwarded request, fetch_dret ack, then RUNNING.
- Ignored commands and reset: dret while RUNNING gets no ack. halt+dret in the same cycle halts. reset in EXECUTE clears everything and passes through on the next cycle.
